// File: rtl/gray_fifo_ptr_ctrl.sv
// gray_fifo_ptr_ctrl
// Pointer controller for a single-clock FIFO. Binary read/write pointers are
// BW_ADDR+1 bits wide (one extra wrap bit). Each pointer is mirrored into a
// Gray-coded register that is loaded on the same edge, so the Gray values can
// later be handed across a clock boundary without extra latency. Full, empty
// and occupancy are computed from the next-state pointers and registered.
// BW_ADDR must be at least 2, because the full test inverts the two Gray MSBs.
module gray_fifo_ptr_ctrl #(
  parameter int BW_ADDR = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_en,
  input  logic               i_rd_en,
  output logic [BW_ADDR-1:0] o_wr_addr,
  output logic [BW_ADDR-1:0] o_rd_addr,
  output logic               o_wr_accept,
  output logic               o_rd_accept,
  output logic [BW_ADDR:0]   o_wr_ptr_gray,
  output logic [BW_ADDR:0]   o_rd_ptr_gray,
  output logic               o_full,
  output logic               o_empty,
  output logic [BW_ADDR:0]   o_count,
  output logic               o_overflow,
  output logic               o_underflow
);

  localparam int PW = BW_ADDR + 1;

  logic [PW-1:0] wr_bin_q, wr_bin_d;
  logic [PW-1:0] rd_bin_q, rd_bin_d;
  logic [PW-1:0] wr_gray_q, wr_gray_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_accept;
  logic          rd_accept;

  // Acceptance uses only the registered flags, so a write into a full FIFO is
  // refused even if a read drains one entry in the same cycle (and vice versa).
  assign wr_accept = i_wr_en & ~full_q;
  assign rd_accept = i_rd_en & ~empty_q;

  // Binary next state: advance by one on accept, wrapping naturally mod 2**PW.
  always_comb begin
    wr_bin_d = wr_bin_q + {{BW_ADDR{1'b0}}, wr_accept};
    rd_bin_d = rd_bin_q + {{BW_ADDR{1'b0}}, rd_accept};
  end

  // Gray conversion of the next-state pointers: g[i] = b[i] ^ b[i+1], MSB passes.
  assign wr_gray_d[PW-1] = wr_bin_d[PW-1];
  assign rd_gray_d[PW-1] = rd_bin_d[PW-1];
  for (genvar gi = 0; gi < PW - 1; gi++) begin : g_gray
    assign wr_gray_d[gi] = wr_bin_d[gi] ^ wr_bin_d[gi+1];
    assign rd_gray_d[gi] = rd_bin_d[gi] ^ rd_bin_d[gi+1];
  end

  // Flag next state from the next-state pointers. In Gray code, a pointer that
  // is exactly one lap ahead differs in the top two bits only.
  always_comb begin
    empty_d     = (wr_gray_d == rd_gray_d);
    full_d      = (wr_gray_d == {~rd_gray_d[PW-1:PW-2], rd_gray_d[PW-3:0]});
    count_d     = wr_bin_d - rd_bin_d;
    overflow_d  = i_wr_en & full_q;
    underflow_d = i_rd_en & empty_q;
  end

  // State register; reset overrides any request presented in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_bin_q    <= '0;
      rd_bin_q    <= '0;
      wr_gray_q   <= '0;
      rd_gray_q   <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_bin_q    <= wr_bin_d;
      rd_bin_q    <= rd_bin_d;
      wr_gray_q   <= wr_gray_d;
      rd_gray_q   <= rd_gray_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_wr_addr     = wr_bin_q[BW_ADDR-1:0];
  assign o_rd_addr     = rd_bin_q[BW_ADDR-1:0];
  assign o_wr_accept   = wr_accept;
  assign o_rd_accept   = rd_accept;
  assign o_wr_ptr_gray = wr_gray_q;
  assign o_rd_ptr_gray = rd_gray_q;
  assign o_full        = full_q;
  assign o_empty       = empty_q;
  assign o_count       = count_q;
  assign o_overflow    = overflow_q;
  assign o_underflow   = underflow_q;

endmodule

// File: tb/tb_gray_fifo_ptr_ctrl.sv
// Testbench for gray_fifo_ptr_ctrl (BW_ADDR = 4, depth 16).
// A driver applies one request per cycle and pushes the expected response
// into a queue; a monitor pops one entry per clocked transaction and compares.
module tb_gray_fifo_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] wr_addr, rd_addr;
  logic       wr_acc, rd_acc;
  logic [4:0] wr_gray, rd_gray;
  logic       full, empty;
  logic [4:0] count;
  logic       ovf, unf;

  int total = 0;
  int bad   = 0;

  gray_fifo_ptr_ctrl #(.BW_ADDR(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wr_en       (wr_en),
    .i_rd_en       (rd_en),
    .o_wr_addr     (wr_addr),
    .o_rd_addr     (rd_addr),
    .o_wr_accept   (wr_acc),
    .o_rd_accept   (rd_acc),
    .o_wr_ptr_gray (wr_gray),
    .o_rd_ptr_gray (rd_gray),
    .o_full        (full),
    .o_empty       (empty),
    .o_count       (count),
    .o_overflow    (ovf),
    .o_underflow   (unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       chk_acc;
    bit       rst;
    bit       wa, ra;
    bit [3:0] waddr, raddr;
    bit [4:0] wg, rg, cnt;
    bit       full, empty, ovf, unf;
    bit       hand_en;
    bit [4:0] hand_wg, hand_rg, hand_cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: integer occupancy, flags derived from occupancy.
  int  m_wr = 0, m_rd = 0, m_cnt = 0;
  bit  m_known = 1'b0;
  bit  hand_pending = 1'b0;
  bit [4:0] hand_wg_v, hand_rg_v, hand_cnt_v;

  function automatic bit [4:0] to_gray(int b);
    bit [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  // One cycle of stimulus plus its expected outcome.
  task automatic step(bit r, bit w, bit rd);
    exp_t e;
    bit m_full, m_empty, aw, ar;
    @(negedge clk);
    rst = r; wr_en = w; rd_en = rd;
    m_full  = (m_cnt == 16);
    m_empty = (m_cnt == 0);
    aw = w & ~m_full;
    ar = rd & ~m_empty;
    e.chk_acc = m_known;
    e.rst = r;
    e.wa = aw;
    e.ra = ar;
    if (r) begin
      m_wr = 0; m_rd = 0; m_cnt = 0;
      e.ovf = 0; e.unf = 0;
      m_known = 1'b1;
    end else begin
      e.ovf = w & m_full;
      e.unf = rd & m_empty;
      m_wr  = (m_wr + int'(aw)) % 32;
      m_rd  = (m_rd + int'(ar)) % 32;
      m_cnt = m_cnt + int'(aw) - int'(ar);
    end
    e.waddr = 4'(m_wr);
    e.raddr = 4'(m_rd);
    e.wg    = to_gray(m_wr);
    e.rg    = to_gray(m_rd);
    e.cnt   = 5'(m_cnt);
    e.full  = (m_cnt == 16);
    e.empty = (m_cnt == 0);
    e.hand_en  = hand_pending;
    e.hand_wg  = hand_wg_v;
    e.hand_rg  = hand_rg_v;
    e.hand_cnt = hand_cnt_v;
    hand_pending = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic hand(bit [4:0] wg, bit [4:0] rg, bit [4:0] c);
    hand_pending = 1'b1;
    hand_wg_v = wg; hand_rg_v = rg; hand_cnt_v = c;
  endtask

  // Monitor: accepts sampled mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    logic s_wa, s_ra;
    logic [4:0] prev_wg, prev_rg;
    int n = 0;
    prev_wg = 'x; prev_rg = 'x;
    forever begin
      @(negedge clk);
      #2;
      s_wa = wr_acc; s_ra = rd_acc;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.chk_acc) begin
          chk("wr_accept", 32'(s_wa), 32'(e.wa));
          chk("rd_accept", 32'(s_ra), 32'(e.ra));
        end
        chk("wr_addr",   32'(wr_addr), 32'(e.waddr));
        chk("rd_addr",   32'(rd_addr), 32'(e.raddr));
        chk("wr_gray",   32'(wr_gray), 32'(e.wg));
        chk("rd_gray",   32'(rd_gray), 32'(e.rg));
        chk("count",     32'(count),   32'(e.cnt));
        chk("full",      32'(full),    32'(e.full));
        chk("empty",     32'(empty),   32'(e.empty));
        chk("overflow",  32'(ovf),     32'(e.ovf));
        chk("underflow", 32'(unf),     32'(e.unf));
        chk("full_and_empty", 32'(full & empty), 32'd0);
        if (e.hand_en) begin
          chk("hand_wr_gray", 32'(wr_gray), 32'(e.hand_wg));
          chk("hand_rd_gray", 32'(rd_gray), 32'(e.hand_rg));
          chk("hand_count",   32'(count),   32'(e.hand_cnt));
        end
        if (!e.rst && !$isunknown(prev_wg) && wr_gray != prev_wg)
          chk("wr_gray_onebit", 32'($countones(wr_gray ^ prev_wg)), 32'd1);
        if (!e.rst && !$isunknown(prev_rg) && rd_gray != prev_rg)
          chk("rd_gray_onebit", 32'($countones(rd_gray ^ prev_rg)), 32'd1);
        prev_wg = wr_gray; prev_rg = rd_gray;
        $display("txn %0d rst=%0b wr=%0b rd=%0b cnt=%0d wg=%b rg=%b full=%0b empty=%0b ovf=%0b unf=%0b",
                 n, e.rst, s_wa, s_ra, count, wr_gray, rd_gray, full, empty, ovf, unf);
        n++;
      end
    end
  end

  // Stimulus
  initial begin
    int guard;
    // 1. reset for two cycles, then idle
    step(1, 0, 0);
    step(1, 0, 0);
    hand(5'b00000, 5'b00000, 5'd0);
    step(0, 0, 0);
    // 2. fill with 16 writes, then a rejected 17th, then idle
    for (int i = 0; i < 15; i++) step(0, 1, 0);
    hand(5'b11000, 5'b00000, 5'd16);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    // 3. drain with 16 reads, then a rejected 17th, then idle
    for (int i = 0; i < 15; i++) step(0, 0, 1);
    hand(5'b11000, 5'b11000, 5'd0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    // 4. preload 5, then 40 cycles of write+read across the pointer wrap
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    for (int i = 0; i < 40; i++) step(0, 1, 1);
    // 5. boundaries: drain to empty, wr+rd on empty; fill, wr+rd on full
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    step(0, 1, 1);
    for (int i = 0; i < 15; i++) step(0, 1, 0);
    step(0, 1, 1);
    step(0, 0, 0);
    // 6. reset with a write request at count 7
    for (int i = 0; i < 8; i++) step(0, 0, 1);
    step(1, 1, 0);
    hand(5'b00000, 5'b00000, 5'd0);
    step(0, 0, 0);
    @(negedge clk);
    rst = 0; wr_en = 0; rd_en = 0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #3;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain act=%0d req=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
